// File: rtl/add_num_pkg.sv
// add_num_pkg: shared types and helpers for the add-two-numbers AFU operand path
package add_num_pkg;

    localparam int OPND_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        OUT
    } t_rd_state;

    typedef struct packed {
        logic [OPND_W_DEF-1:0] a;
        logic [OPND_W_DEF-1:0] b;
    } t_opnd_pair;

    // a sits in the low operand slot of the line, b directly above it
    function automatic t_opnd_pair opnd_slice(input logic [2*OPND_W_DEF-1:0] lo);
        t_opnd_pair p;
        p.a = lo[OPND_W_DEF-1:0];
        p.b = lo[2*OPND_W_DEF-1:OPND_W_DEF];
        return p;
    endfunction

endpackage

// File: rtl/add_num_watchdog.sv
// add_num_watchdog: counts cycles while run_i is high and flags the cycle the limit is hit
module add_num_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // count only while waiting; any other cycle re-arms the counter at zero
    always_comb cnt_d = run_i ? cnt_q + CNT_W'(1) : '0;

    // counter register
    always_ff @(posedge clk)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/add_num_rd_engine.sv
// add_num_rd_engine: fetches one cache line over CCI-P c0 and hands operands a/b downstream.
// Optional response watchdog enabled with ADD_NUM_RD_TIMEOUT_EN.
module add_num_rd_engine
    import add_num_pkg::*;
#(
    parameter int ADDR_W         = 42,
    parameter int DATA_W         = 512,
    parameter int MDATA_W        = 16,
    parameter int OPND_W         = OPND_W_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    output logic               busy,
    input  logic               c0_almfull,
    output logic               c0_req_valid,
    output logic [ADDR_W-1:0]  c0_req_addr,
    output logic [MDATA_W-1:0] c0_req_mdata,
    input  logic               c0_rsp_valid,
    input  logic [MDATA_W-1:0] c0_rsp_mdata,
    input  logic [DATA_W-1:0]  c0_rsp_data,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [OPND_W-1:0]  op_a,
    output logic [OPND_W-1:0]  op_b,
    output logic               done,
    output logic               err
);

    t_rd_state          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [MDATA_W-1:0] tag_q, tag_d;
    logic               req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [MDATA_W-1:0] req_mdata_q, req_mdata_d;
    logic               op_valid_q, op_valid_d;
    logic [OPND_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic               done_q, done_d, err_q, err_d;
    logic               rsp_hit, timeout;
    logic               rsp_unused;

    // only the issued tag counts; everything else on c0 belongs to someone else or is stale
    assign rsp_hit    = c0_rsp_valid && (c0_rsp_mdata == req_mdata_q);
    assign rsp_unused = ^c0_rsp_data[DATA_W-1:2*OPND_W];

`ifdef ADD_NUM_RD_TIMEOUT_EN
    add_num_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .run_i    (state_q == WAIT_RSP),
        .expired_o(timeout)
    );
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // fetch sequencing: a matching response outranks a same-cycle timeout
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tag_d       = tag_q;
        req_valid_d = 1'b0;
        req_addr_d  = req_addr_q;
        req_mdata_d = req_mdata_q;
        op_valid_d  = op_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = start_addr;
                state_d = REQ;
            end
            REQ: if (!c0_almfull) begin
                req_valid_d = 1'b1;
                req_addr_d  = addr_q;
                req_mdata_d = tag_q;
                tag_d       = tag_q + MDATA_W'(1);
                state_d     = WAIT_RSP;
            end
            WAIT_RSP: if (rsp_hit) begin
                op_valid_d = 1'b1;
                op_a_d     = c0_rsp_data[OPND_W-1:0];
                op_b_d     = c0_rsp_data[2*OPND_W-1:OPND_W];
                state_d    = OUT;
            end else if (timeout) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            OUT: if (op_ready) begin
                op_valid_d = 1'b0;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            tag_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_mdata_q <= '0;
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tag_q       <= tag_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_mdata_q <= req_mdata_d;
            op_valid_q  <= op_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign c0_req_valid = req_valid_q;
    assign c0_req_addr  = req_addr_q;
    assign c0_req_mdata = req_mdata_q;
    assign op_valid     = op_valid_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_add_num_rd_engine.sv
// tb_add_num_rd_engine: scoreboard bench for the operand-fetch engine
module tb_add_num_rd_engine;

    localparam int ADDR_W  = 42;
    localparam int DATA_W  = 512;
    localparam int MDATA_W = 16;
    localparam int OPND_W  = 8;
    localparam int TO      = 16;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [ADDR_W-1:0]  start_addr = '0;
    logic               busy;
    logic               c0_almfull = 1'b0;
    logic               c0_req_valid;
    logic [ADDR_W-1:0]  c0_req_addr;
    logic [MDATA_W-1:0] c0_req_mdata;
    logic               c0_rsp_valid = 1'b0;
    logic [MDATA_W-1:0] c0_rsp_mdata = '0;
    logic [DATA_W-1:0]  c0_rsp_data = '0;
    logic               op_valid;
    logic               op_ready = 1'b0;
    logic [OPND_W-1:0]  op_a, op_b;
    logic               done, err;

    always #5 clk = ~clk;

    add_num_rd_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MDATA_W(MDATA_W),
        .OPND_W(OPND_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr), .busy(busy),
        .c0_almfull(c0_almfull), .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
        .c0_req_mdata(c0_req_mdata), .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata),
        .c0_rsp_data(c0_rsp_data), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .done(done), .err(err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [MDATA_W-1:0] mdata;
    } req_t;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } opnd_t;

    req_t               exp_req[$];
    opnd_t              exp_op[$];
    logic [MDATA_W-1:0] model_tag = '0;
    int                 n_cmp = 0;
    int                 n_bad = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_fetch(input logic [ADDR_W-1:0] a);
        start      = 1'b1;
        start_addr = a;
        exp_req.push_back('{addr: a, mdata: model_tag});
        model_tag  = model_tag + 1'b1;
        tick;
        start      = 1'b0;
        start_addr = '1;
    endtask

    task automatic expect_req(input int lat, input string nm);
        int   k = 0;
        req_t e = '0;
        while (c0_req_valid !== 1'b1 && k < 64) begin
            tick;
            k++;
        end
        n_cmp++;
        if (c0_req_valid !== 1'b1 || k != lat) begin
            n_bad++;
            $display("FAIL %s req_latency: got %0d cycles (valid=%b), want %0d", nm, k, c0_req_valid, lat);
        end
        if (exp_req.size() != 0) e = exp_req.pop_front();
        n_cmp++;
        if (c0_req_addr !== e.addr || c0_req_mdata !== e.mdata) begin
            n_bad++;
            $display("FAIL %s req_fields: got addr=%h mdata=%h, want addr=%h mdata=%h",
                     nm, c0_req_addr, c0_req_mdata, e.addr, e.mdata);
        end
        tick;
        n_cmp++;
        if (c0_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s req_pulse: got valid=%b, want 0", nm, c0_req_valid);
        end
    endtask

    task automatic send_rsp(input logic [MDATA_W-1:0] md, input logic [15:0] lo, input bit hit);
        logic [DATA_W-1:0] line;
        for (int i = 0; i < DATA_W / 32; i++) line[i*32 +: 32] = $urandom;
        line[15:0]   = lo;
        c0_rsp_valid = 1'b1;
        c0_rsp_mdata = md;
        c0_rsp_data  = line;
        if (hit) exp_op.push_back('{a: lo[7:0], b: lo[15:8]});
        tick;
        c0_rsp_valid = 1'b0;
        c0_rsp_mdata = '0;
        c0_rsp_data  = '0;
    endtask

    task automatic expect_op(input int lat, input int hold, input string nm);
        int    k = 0;
        opnd_t e = '0;
        while (op_valid !== 1'b1 && k < 64) begin
            tick;
            k++;
        end
        n_cmp++;
        if (op_valid !== 1'b1 || k != lat) begin
            n_bad++;
            $display("FAIL %s op_latency: got %0d cycles (valid=%b), want %0d", nm, k, op_valid, lat);
        end
        if (exp_op.size() != 0) e = exp_op.pop_front();
        n_cmp++;
        if (op_a !== e.a || op_b !== e.b) begin
            n_bad++;
            $display("FAIL %s operands: got a=%h b=%h, want a=%h b=%h", nm, op_a, op_b, e.a, e.b);
        end
        for (int i = 0; i < hold; i++) begin
            tick;
            n_cmp++;
            if (op_valid !== 1'b1 || done !== 1'b0 || op_a !== e.a || op_b !== e.b) begin
                n_bad++;
                $display("FAIL %s hold: got valid=%b done=%b a=%h b=%h, want 1 0 %h %h",
                         nm, op_valid, done, op_a, op_b, e.a, e.b);
            end
        end
        op_ready = 1'b1;
        tick;
        op_ready = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || op_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s accept: got done=%b valid=%b busy=%b, want 1 0 0", nm, done, op_valid, busy);
        end
        tick;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done_pulse: got done=%b, want 0", nm, done);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick;
        tick;
        n_cmp++;
        if ({busy, c0_req_valid, op_valid, done, err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, want 00000", {busy, c0_req_valid, op_valid, done, err});
        end
        n_cmp++;
        if (c0_req_addr !== '0 || c0_req_mdata !== '0) begin
            n_bad++;
            $display("FAIL reset_req: got addr=%h mdata=%h, want 0 0", c0_req_addr, c0_req_mdata);
        end
        n_cmp++;
        if (op_a !== '0 || op_b !== '0) begin
            n_bad++;
            $display("FAIL reset_ops: got a=%h b=%h, want 0 0", op_a, op_b);
        end
        reset_n   = 1'b1;
        model_tag = '0;
        tick;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_basic;
        start_fetch(42'h100);
        expect_req(1, "basic");
        repeat (4) begin
            tick;
            n_cmp++;
            if (op_valid !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL basic wait: got valid=%b busy=%b, want 0 1", op_valid, busy);
            end
        end
        send_rsp(16'h0, 16'h0705, 1'b1);
        expect_op(0, 0, "basic");
    endtask

    task automatic test_stale;
        start_fetch(42'h1C0);
        expect_req(1, "stale");
        send_rsp(16'h0, 16'hBEEF, 1'b0);
        n_cmp++;
        if (op_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stale drop: got valid=%b busy=%b, want 0 1", op_valid, busy);
        end
        send_rsp(16'h1, 16'h0302, 1'b1);
        expect_op(0, 0, "stale");
    endtask

    task automatic test_backpressure;
        c0_almfull = 1'b1;
        start_fetch(42'h2A5);
        repeat (9) begin
            tick;
            n_cmp++;
            if (c0_req_valid !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL bp stall: got valid=%b busy=%b, want 0 1", c0_req_valid, busy);
            end
        end
        c0_almfull = 1'b0;
        expect_req(1, "bp");
        send_rsp(16'h2, 16'h1234, 1'b1);
        expect_op(0, 4, "bp");
    endtask

    task automatic test_start_busy;
        int reqs = 0;
        int dones = 0;
        start_fetch(42'h3C0);
        expect_req(1, "busy");
        start      = 1'b1;
        start_addr = 42'h3FF;
        tick;
        start      = 1'b0;
        repeat (6) begin
            tick;
            if (c0_req_valid === 1'b1) reqs++;
        end
        n_cmp++;
        if (reqs != 0) begin
            n_bad++;
            $display("FAIL busy extra_req: got %0d requests, want 0", reqs);
        end
        send_rsp(16'h3, 16'h665A, 1'b1);
        expect_op(0, 1, "busy");
        reqs = 0;
        repeat (5) begin
            tick;
            if (c0_req_valid === 1'b1) reqs++;
            if (done === 1'b1) dones++;
        end
        n_cmp++;
        if (reqs != 0 || dones != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy aftermath: got reqs=%0d dones=%0d busy=%b, want 0 0 0", reqs, dones, busy);
        end
    endtask

    task automatic test_reset_mid;
        start_fetch(42'h440);
        expect_req(1, "rst");
        reset_n = 1'b0;
        tick;
        reset_n   = 1'b1;
        model_tag = '0;
        n_cmp++;
        if (busy !== 1'b0 || op_valid !== 1'b0 || c0_req_mdata !== '0) begin
            n_bad++;
            $display("FAIL rst state: got busy=%b valid=%b mdata=%h, want 0 0 0", busy, op_valid, c0_req_mdata);
        end
        send_rsp(16'h4, 16'h1111, 1'b0);
        n_cmp++;
        if (op_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst late_rsp: got valid=%b busy=%b, want 0 0", op_valid, busy);
        end
        start_fetch(42'h480);
        expect_req(1, "rst_rearm");
        send_rsp(16'h0, 16'h0908, 1'b1);
        expect_op(0, 0, "rst_rearm");
    endtask

`ifdef ADD_NUM_RD_TIMEOUT_EN
    task automatic test_timeout;
        int k = 0;
        start_fetch(42'h500);
        expect_req(1, "timeout");
        while (err !== 1'b1 && k < 64) begin
            n_cmp++;
            if (op_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout wait: got valid=%b, want 0", op_valid);
            end
            tick;
            k++;
        end
        n_cmp++;
        if (err !== 1'b1 || k != TO - 1 || busy !== 1'b0 || op_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout err: got err=%b after %0d cycles busy=%b valid=%b, want 1 %0d 0 0",
                     err, k, busy, op_valid, TO - 1);
        end
        tick;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout err_pulse: got err=%b, want 0", err);
        end
        send_rsp(16'h1, 16'h2222, 1'b0);
        n_cmp++;
        if (op_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout late_rsp: got valid=%b busy=%b, want 0 0", op_valid, busy);
        end
    endtask

    task automatic test_timeout_race;
        start_fetch(42'h540);
        expect_req(1, "race");
        repeat (TO - 2) tick;
        send_rsp(16'h2, 16'h0C0B, 1'b1);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL race err: got err=%b, want 0", err);
        end
        expect_op(0, 0, "race");
    endtask
`else
    task automatic test_no_timeout;
        int errs = 0;
        start_fetch(42'h500);
        expect_req(1, "no_timeout");
        repeat (40) begin
            tick;
            if (err !== 1'b0) errs++;
        end
        n_cmp++;
        if (errs != 0 || busy !== 1'b1 || op_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL no_timeout wait: got errs=%0d busy=%b valid=%b, want 0 1 0", errs, busy, op_valid);
        end
        send_rsp(16'h1, 16'h0D0E, 1'b1);
        expect_op(0, 0, "no_timeout");
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_stale;
        test_backpressure;
        test_start_busy;
        test_reset_mid;
`ifdef ADD_NUM_RD_TIMEOUT_EN
        test_timeout;
        test_timeout_race;
`else
        test_no_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/add_num_rd_engine.md
Name: add_num_rd_engine

Overview:
- Operand-fetch stage that sits directly upstream of the add-two-numbers AFU datapath.
- On a start pulse (issued when the CSR path latches the operand buffer address), it issues one CCI-P c0 cache-line read to host memory and waits for the matching response.
- It extracts operands a and b from the returned line and presents them on a valid/ready interface to the adder/write stage.
- Only one read is in flight at a time; a tag in mdata rejects stale or foreign responses.

Parameters:
ADDR_W, 42, cache-line address width (t_ccip_clAddr)
DATA_W, 512, cache-line data width (t_ccip_clData)
MDATA_W, 16, request/response tag width
OPND_W, 8, operand width; a = line[OPND_W-1:0], b = line[2*OPND_W-1:OPND_W]
TIMEOUT_CYCLES, 1024, response watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse: begin a fetch from start_addr
start_addr  in  ADDR_W  cache-line address of the operand buffer
busy  out  1  high in any state other than IDLE
c0_almfull  in  1  host c0TxAlmFull
c0_req_valid  out  1  read request valid (one-cycle pulse)
c0_req_addr  out  ADDR_W  read request address
c0_req_mdata  out  MDATA_W  read request tag
c0_rsp_valid  in  1  read response valid (rspValid, resp_type = read)
c0_rsp_mdata  in  MDATA_W  response tag
c0_rsp_data  in  DATA_W  response cache line
op_valid  out  1  operands available
op_ready  in  1  downstream accepts operands
op_a  out  OPND_W  operand a
op_b  out  OPND_W  operand b
done  out  1  one-cycle pulse when operands are accepted
err  out  1  one-cycle pulse on timeout (held 0 when the feature is compiled out)

Behaviour:
- Reset values: state = IDLE; tag = 0; busy, c0_req_valid, op_valid, done, err = 0; c0_req_addr, c0_req_mdata, op_a, op_b = 0.
- States: IDLE, REQ, WAIT_RSP, OUT.
- IDLE:
  - start = 1: latch start_addr, go to REQ.
  - start while not in IDLE: ignored, no queuing.
- REQ:
  - c0_almfull = 1: stall in REQ, no request issued.
  - Otherwise, next cycle drives c0_req_valid = 1 for exactly one cycle, with c0_req_addr = latched address and c0_req_mdata = tag. Then go to WAIT_RSP.
  - tag increments (mod 2^MDATA_W, wraps) on each issue, after it is used.
- WAIT_RSP:
  - c0_rsp_valid with c0_rsp_mdata == issued tag: register op_a/op_b from c0_rsp_data, go to OUT.
  - Non-matching responses: dropped silently, stay in WAIT_RSP.
  - The response may arrive at the earliest in the cycle after c0_req_valid. A response in the same cycle as the request is not possible and need not be handled.
- OUT:
  - op_valid = 1; op_a/op_b held stable until op_ready.
  - op_valid && op_ready: done pulses in the next cycle, op_valid drops, go to IDLE.
  - A start in that same handshake cycle is ignored.
- Latency: start to c0_req_valid = 2 cycles (no almfull); response to op_valid = 1 cycle; minimum start to op_valid = 3 cycles + host latency.
- busy = (state != IDLE), registered from state.
- Reset mid-operation:
  - Everything returns to reset values; tag returns to 0.
  - A late response after reset must not produce op_valid unless a new request is outstanding with an equal tag. This is acceptable, but software must drain before re-arming.
- No arithmetic beyond tag increment; operand bits above 2*OPND_W in the line are ignored.

Optional Feature:
- Macro: ADD_NUM_RD_TIMEOUT_EN.
- Defined:
  - A cycle counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to WAIT_RSP and counts each cycle in WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES with no matching response: err pulses for one cycle, go to IDLE, op_valid stays 0.
  - The tag has already advanced, so the late response is dropped as stale.
  - A matching response in the same cycle as the limit wins; no err.
- Not defined: no counter logic; err is tied to 0; WAIT_RSP waits indefinitely.

Decomposition:
- Shared package add_num_pkg:
  - t_rd_state enum {IDLE, REQ, WAIT_RSP, OUT}.
  - OPND_W default constant.
  - Operand-slice helper function (line -> a, b).
  - t_opnd_pair struct {a, b}, reused by the downstream adder stage.
- One sub-module is natural: add_num_watchdog (counter + expiry), instantiated only under ADD_NUM_RD_TIMEOUT_EN.

Test Plan:
- Basic fetch: start with start_addr = 0x100, almfull = 0; response 5 cycles after the request, tag 0, data[15:0] = 0x0705. Expect c0_req_valid 2 cycles after start with addr 0x100 and mdata 0; op_valid with op_a = 0x05, op_b = 0x07; op_ready = 1 gives done the next cycle.
- Backpressure: almfull high for 10 cycles after start -> no request during those cycles; request 1 cycle after almfull falls. op_ready low 4 cycles -> op_a/op_b stable, done only after acceptance.
- Stale tag: second fetch (tag 1); inject a response with mdata 0 first, then mdata 1 with data 0x0302. Expect op_a = 0x02, op_b = 0x03, mdata-0 line ignored.
- Start while busy: a second start pulse during WAIT_RSP -> no second request; exactly one done.
- Reset mid-op: reset_n low for 1 cycle during WAIT_RSP -> busy = 0, op_valid = 0; the next start issues mdata 0.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): no response -> err pulse 16 cycles into WAIT_RSP, busy drops, no op_valid. A later mdata 0 response is ignored.
